// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the core PC, issues one imem fetch per instruction and buffers the word for decode.
// Latency start->imem_req 1 cycle, imem_ack->instr_valid 1 cycle; instr_ready low holds the word (no new fetch).
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       INC      = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              halt_i,
  input  logic              redirect_valid_i,
  input  logic              redirect_rel_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_data_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALTED} state_t;

  localparam logic [ADDR_W-1:0] INC_A = ADDR_W'(INC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_halt_q, pend_halt_d;
  logic              pend_redir_q, pend_redir_d;
  logic              req_q, valid_q, busy_q;
  logic [ADDR_W-1:0] redir_tgt;

  // Relative redirects are always based on the last delivered instruction.
  assign redir_tgt = redirect_rel_i ? (instr_pc_q + redirect_target_i) : redirect_target_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_pc_d   = instr_pc_q;
    instr_data_d = instr_data_q;
    pend_tgt_d   = pend_tgt_q;
    pend_halt_d  = pend_halt_q;
    pend_redir_d = pend_redir_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          pc_d    = RESET_PC;
        end
      end
      S_REQ: begin
        // The request cannot be withdrawn, so flow changes wait for the ack.
        if (halt_i) pend_halt_d = 1'b1;
        if (redirect_valid_i) begin
          pend_redir_d = 1'b1;
          pend_tgt_d   = redir_tgt;
        end
        if (imem_ack_i) begin
          pend_halt_d  = 1'b0;
          pend_redir_d = 1'b0;
          if (halt_i || pend_halt_q) begin
            state_d = S_HALTED;
          end else if (redirect_valid_i || pend_redir_q) begin
            pc_d = redirect_valid_i ? redir_tgt : pend_tgt_q;
          end else begin
            instr_data_d = imem_rdata_i;
            instr_pc_d   = pc_q;
            pc_d         = pc_q + INC_A;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (halt_i) begin
          state_d = S_HALTED;
        end else if (redirect_valid_i) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (instr_ready_i) begin
          state_d = S_REQ;
        end
      end
      S_HALTED: begin
        if (start_i && !halt_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_pc_q   <= '0;
      instr_data_q <= '0;
      pend_tgt_q   <= '0;
      pend_halt_q  <= 1'b0;
      pend_redir_q <= 1'b0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_pc_q   <= instr_pc_d;
      instr_data_q <= instr_data_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_halt_q  <= pend_halt_d;
      pend_redir_q <= pend_redir_d;
      req_q        <= (state_d == S_REQ);
      valid_q      <= (state_d == S_HOLD);
      busy_q       <= (state_d == S_REQ) || (state_d == S_HOLD);
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_data_o  = instr_data_q;
  assign instr_pc_o    = instr_pc_q;
  assign pc_o          = pc_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the fetch/deliver/halt rules.
module tb_fetch_sequencer;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, halt, redir, rel, ack, ready;
  logic [AW-1:0] tgt;
  logic [DW-1:0] rdata;
  logic          req, ivld, busy;
  logic [AW-1:0] addr, ipc, pc;
  logic [DW-1:0] idata;

  fetch_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .halt_i(halt),
    .redirect_valid_i(redir), .redirect_rel_i(rel), .redirect_target_i(tgt),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .instr_valid_o(ivld), .instr_data_o(idata), .instr_pc_o(ipc), .instr_ready_i(ready),
    .pc_o(pc), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: which phase of the fetch protocol we are in, plus flow changes waiting for an ack.
  localparam int M_IDLE = 0, M_FETCH = 1, M_DELIVER = 2, M_HALTED = 3;
  int            m_mode;
  logic [AW-1:0] m_pc, m_ipc, m_ptgt;
  logic [DW-1:0] m_idata;
  bit            m_phalt, m_predir;

  // Memory responder
  int  ack_cnt, ack_dly, fixed_dly;
  bit  rand_mem;
  logic [AW-1:0] ack_log[$];
  logic [AW-1:0] pc_log[$];
  logic [DW-1:0] dat_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] target_now();
    return rel ? AW'(m_ipc + tgt) : tgt;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_pc = '0; m_ipc = '0; m_idata = '0;
    m_ptgt = '0; m_phalt = 1'b0; m_predir = 1'b0;
  endfunction

  function automatic void model_step();
    case (m_mode)
      M_IDLE: if (start) begin m_mode = M_FETCH; m_pc = '0; end
      M_FETCH: begin
        if (halt) m_phalt = 1'b1;
        if (redir) begin m_predir = 1'b1; m_ptgt = target_now(); end
        if (ack) begin
          if (m_phalt) m_mode = M_HALTED;
          else if (m_predir) m_pc = m_ptgt;
          else begin
            m_idata = rdata; m_ipc = m_pc; m_pc = AW'(m_pc + 1); m_mode = M_DELIVER;
          end
          m_phalt = 1'b0; m_predir = 1'b0;
        end
      end
      M_DELIVER: begin
        if (halt) m_mode = M_HALTED;
        else if (redir) begin m_pc = target_now(); m_mode = M_FETCH; end
        else if (ready) m_mode = M_FETCH;
      end
      default: if (start && !halt) m_mode = M_FETCH;
    endcase
  endfunction

  task automatic compare();
    logic er, ev;
    er = (m_mode == M_FETCH);
    ev = (m_mode == M_DELIVER);
    chk("imem_req", 32'(req), 32'(er));
    chk("instr_valid", 32'(ivld), 32'(ev));
    chk("busy", 32'(busy), 32'(er | ev));
    chk("pc", 32'(pc), 32'(m_pc));
    if (er) chk("imem_addr", 32'(addr), 32'(m_pc));
    if (ev) begin
      chk("instr_data", 32'(idata), 32'(m_idata));
      chk("instr_pc", 32'(ipc), 32'(m_ipc));
    end
  endtask

  task automatic set_dly(input int d);
    fixed_dly = d;
    ack_dly   = d;
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    ack   = req && (ack_cnt >= ack_dly);
    rdata = rand_mem ? DW'($urandom()) : DW'(16'h1000 + {4'h0, addr});
    if (ack) begin
      ack_log.push_back(addr);
      ack_cnt = 0;
      ack_dly = rand_mem ? int'($urandom_range(0, 3)) : fixed_dly;
    end else if (req) begin
      ack_cnt++;
    end
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (ivld) begin pc_log.push_back(ipc); dat_log.push_back(idata); end
    @(negedge clk);
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (!ivld && n < maxc) begin step(); n++; end
    chk("wait_valid", 32'(ivld), 32'd1);
  endtask

  // Asynchronous reset from mid-cycle; imem_req must fall without a clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_async", 32'(req), 32'd0);
    chk("rst_busy_async", 32'(busy), 32'd0);
    chk("rst_valid_async", 32'(ivld), 32'd0);
    model_reset();
    ack = 1'b0; ack_cnt = 0; ack_dly = fixed_dly;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] p0, a0;
    logic [DW-1:0] d0;
    int first;
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; redir = 1'b0; rel = 1'b0; tgt = '0;
    ack = 1'b0; rdata = '0; ready = 1'b1;
    rand_mem = 1'b0; ack_cnt = 0; set_dly(1);
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_req", 32'(req), 32'd0);
    chk("reset_valid", 32'(ivld), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_idata", 32'(idata), 32'd0);
    chk("reset_ipc", 32'(ipc), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Sequential fetch from reset, ack one cycle after each request.
    ack_log.delete(); pc_log.delete(); dat_log.delete();
    start = 1'b1;
    first = -1;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (ivld && first < 0) first = c;
    end
    chk("t1_first_valid_cycle", 32'(first), 32'd3);
    chk("t1_enough", 32'(ack_log.size() >= 4 && pc_log.size() >= 4), 32'd1);
    if (ack_log.size() >= 4 && pc_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_imem_addr", 32'(ack_log[i]), i);
        chk("t1_instr_pc", 32'(pc_log[i]), i);
        chk("t1_instr_data", 32'(dat_log[i]), 32'h1000 + i);
      end
    end
    start = 1'b0;

    // Decoder stall in HOLD.
    wait_valid(20);
    ready = 1'b0;
    d0 = idata; p0 = ipc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_valid", 32'(ivld), 32'd1);
      chk("t2_data", 32'(idata), 32'(d0));
      chk("t2_ipc", 32'(ipc), 32'(p0));
      chk("t2_req", 32'(req), 32'd0);
      chk("t2_pc", 32'(pc), 32'(AW'(p0 + 1)));
    end
    ready = 1'b1;

    // Redirects from HOLD: absolute to 0x010, relative -4, absolute 0x200.
    redir = 1'b1; rel = 1'b0; tgt = 12'h010; step(); redir = 1'b0;
    wait_valid(20);
    chk("t3_ipc_010", 32'(ipc), 32'h010);
    redir = 1'b1; rel = 1'b1; tgt = 12'hFFC; step(); redir = 1'b0;
    chk("t3_rel_addr", 32'(addr), 32'h00C);
    chk("t3_rel_flush", 32'(ivld), 32'd0);
    wait_valid(20);
    redir = 1'b1; rel = 1'b0; tgt = 12'h200; step(); redir = 1'b0;
    chk("t3_abs_addr", 32'(addr), 32'h200);

    // Redirect while a slow fetch is outstanding.
    wait_valid(20);
    set_dly(3);
    step();
    a0 = addr;
    chk("t4_req", 32'(req), 32'd1);
    redir = 1'b1; rel = 1'b0; tgt = 12'h123; step(); redir = 1'b0;
    for (int k = 0; k < 8 && !ack; k++) begin
      chk("t4_addr_stable", 32'(addr), 32'(a0));
      chk("t4_no_valid", 32'(ivld), 32'd0);
      step();
    end
    chk("t4_acked", 32'(ack), 32'd1);
    chk("t4_new_addr", 32'(addr), 32'h123);
    chk("t4_discard", 32'(ivld), 32'd0);

    // PC wrap at the top of the address space.
    set_dly(0);
    wait_valid(20);
    redir = 1'b1; rel = 1'b0; tgt = 12'hFFF; step(); redir = 1'b0;
    wait_valid(20);
    chk("t5_ipc", 32'(ipc), 32'hFFF);
    chk("t5_pc", 32'(pc), 32'h000);
    step();
    chk("t5_addr", 32'(addr), 32'h000);

    // Halt in HOLD, start ignored while halt is high, resume at held pc.
    wait_valid(20);
    halt = 1'b1; step();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(ivld), 32'd0);
    p0 = pc;
    start = 1'b1;
    repeat (3) begin
      step();
      chk("t6_halted_req", 32'(req), 32'd0);
      chk("t6_halted_pc", 32'(pc), 32'(p0));
    end
    halt = 1'b0; step(); start = 1'b0;
    chk("t6_resume_req", 32'(req), 32'd1);
    chk("t6_resume_addr", 32'(addr), 32'(p0));
    set_dly(3);
    step();
    do_reset();
    step();
    chk("t6_idle_pc", 32'(pc), 32'd0);
    chk("t6_idle_req", 32'(req), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    rand_mem = 1'b1;
    ack_dly = 0;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 5) == 0);
      halt  = ($urandom_range(0, 15) == 0);
      redir = ($urandom_range(0, 7) == 0);
      rel   = $urandom_range(0, 1) == 1;
      tgt   = AW'($urandom());
      ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
